// File: rtl/nav_sequencer_if.sv
// Command and datapath-control bundle between a navigation command source and nav_sequencer.
interface nav_sequencer_if #(
   parameter int K      = 16,
   parameter int STEP_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [3:0]        cmd_speed;
   logic [STEP_W-1:0] cmd_steps;
   logic [3*K-1:0]    cmd_target;
   logic              abort;
   logic [3:0]        mode;
   logic [3:0]        pos_mode;
   logic [3*K-1:0]    jump_position;
   logic              busy;
   logic              done;
   logic              aborted;
   logic              err;

   modport master (
      output cmd_valid, cmd_op, cmd_speed, cmd_steps, cmd_target, abort,
      input  cmd_ready, mode, pos_mode, jump_position, busy, done, aborted, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_speed, cmd_steps, cmd_target, abort,
      output cmd_ready, mode, pos_mode, jump_position, busy, done, aborted, err
   );
endinterface

// File: rtl/nav_sequencer.sv
// Command sequencer for the three-axis position datapath: zero, timed cruise, charged jump.
// Next state is decoded combinationally; every output is a register derived from that next state.
module nav_sequencer #(
   parameter int K               = 16,
   parameter int STEP_W          = 8,
   parameter int CHARGE_CYCLES   = 4,
   parameter int COOLDOWN_CYCLES = 3
) (
   input logic           clk,
   input logic           rst_n,
   nav_sequencer_if.slave bus
);
   localparam int MAX_T = (CHARGE_CYCLES > COOLDOWN_CYCLES) ? CHARGE_CYCLES : COOLDOWN_CYCLES;
   localparam int TMR_W = $clog2(MAX_T + 1);

   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_ZERO   = 3'd2;
   localparam logic [2:0] S_CRUISE = 3'd3;
   localparam logic [2:0] S_CHARGE = 3'd4;
   localparam logic [2:0] S_JUMP   = 3'd5;
   localparam logic [2:0] S_COOL   = 3'd6;

   localparam logic [3:0] M_STOP = 4'b0001;
   localparam logic [3:0] P_ZERO = 4'b0001;
   localparam logic [3:0] P_SUB  = 4'b0010;
   localparam logic [3:0] P_JUMP = 4'b0100;

   logic [2:0]        state, state_d;
   logic [STEP_W-1:0] step_cnt, step_d;
   logic [TMR_W-1:0]  tmr, tmr_d;
   logic [3:0]        spd_q, spd_d;
   logic [3*K-1:0]    tgt_q, tgt_d;
   logic              done_d, aborted_d, err_d;
   logic [3:0]        mode_d, pos_mode_d;
   logic [3*K-1:0]    jp_d;
   logic              spd_ok;

   assign spd_ok = (bus.cmd_speed != 4'd0) && ((bus.cmd_speed & (bus.cmd_speed - 4'd1)) == 4'd0);

   always_comb begin
      state_d   = state;
      step_d    = step_cnt;
      tmr_d     = tmr;
      spd_d     = spd_q;
      tgt_d     = tgt_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      err_d     = 1'b0;
      case (state)
         S_INIT: state_d = S_IDLE;
         S_IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               case (bus.cmd_op)
                  2'b00: state_d = S_ZERO;
                  2'b01: begin
                     if (!spd_ok) err_d = 1'b1;
                     else if (bus.cmd_steps == '0) done_d = 1'b1;
                     else begin
                        state_d = S_CRUISE;
                        step_d  = bus.cmd_steps;
                        spd_d   = bus.cmd_speed;
                     end
                  end
                  2'b10: begin
                     state_d = S_CHARGE;
                     tmr_d   = TMR_W'(CHARGE_CYCLES);
                     tgt_d   = bus.cmd_target;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_ZERO: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         // abort is checked first so it beats completion on the same edge
         S_CRUISE: begin
            if (bus.abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (step_cnt == STEP_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else step_d = step_cnt - STEP_W'(1);
         end
         S_CHARGE: begin
            if (bus.abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (tmr == TMR_W'(1)) state_d = S_JUMP;
            else tmr_d = tmr - TMR_W'(1);
         end
         S_JUMP: begin
            state_d = S_COOL;
            tmr_d   = TMR_W'(COOLDOWN_CYCLES);
         end
         S_COOL: begin
            if (tmr == TMR_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else tmr_d = tmr - TMR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      mode_d = (state_d == S_CRUISE) ? spd_d : M_STOP;
      case (state_d)
         S_ZERO:  pos_mode_d = P_ZERO;
         S_JUMP:  pos_mode_d = P_JUMP;
         default: pos_mode_d = P_SUB;
      endcase
      jp_d = (state_d == S_JUMP) ? tgt_q : bus.jump_position;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_INIT;
         step_cnt          <= '0;
         tmr               <= '0;
         spd_q             <= M_STOP;
         tgt_q             <= '0;
         bus.mode          <= M_STOP;
         bus.pos_mode      <= P_ZERO;
         bus.jump_position <= '0;
         bus.cmd_ready     <= 1'b0;
         bus.busy          <= 1'b1;
         bus.done          <= 1'b0;
         bus.aborted       <= 1'b0;
         bus.err           <= 1'b0;
      end else begin
         state             <= state_d;
         step_cnt          <= step_d;
         tmr               <= tmr_d;
         spd_q             <= spd_d;
         tgt_q             <= tgt_d;
         bus.mode          <= mode_d;
         bus.pos_mode      <= pos_mode_d;
         bus.jump_position <= jp_d;
         bus.cmd_ready     <= (state_d == S_IDLE);
         bus.busy          <= (state_d != S_IDLE);
         bus.done          <= done_d;
         bus.aborted       <= aborted_d;
         bus.err           <= err_d;
      end
   end
endmodule

// File: tb/tb_nav_sequencer.sv
// Directed bench for nav_sequencer with a small three-axis position datapath model.
module tb_nav_sequencer;
   localparam int K = 16, STEP_W = 8, C = 4, D = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   nav_sequencer_if #(.K(K), .STEP_W(STEP_W)) bus ();

   nav_sequencer #(.K(K), .STEP_W(STEP_W), .CHARGE_CYCLES(C), .COOLDOWN_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // datapath: stop 0, attack 1, defense 2, stealth 4 per axis
   logic [K-1:0] pos [3];
   function automatic logic [K-1:0] vel(input logic [3:0] m);
      case (m)
         4'b0010: return K'(1);
         4'b0100: return K'(2);
         4'b1000: return K'(4);
         default: return '0;
      endcase
   endfunction

   always @(posedge clk) begin
      for (int a = 0; a < 3; a++) begin
         case (bus.pos_mode)
            4'b0001: pos[a] <= '0;
            4'b0010: pos[a] <= pos[a] + vel(bus.mode);
            4'b0100: pos[a] <= bus.jump_position[a*K +: K];
            default: pos[a] <= pos[a];
         endcase
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".mode"}, 64'(bus.mode), 64'h1);
      chk({tag, ".pos_mode"}, 64'(bus.pos_mode), 64'h2);
      chk({tag, ".rdy_busy"}, 64'({bus.cmd_ready, bus.busy}), 64'b10);
   endtask

   task automatic pos_chk(input string tag, input logic [K-1:0] x, input logic [K-1:0] y,
                          input logic [K-1:0] z);
      chk({tag, ".x"}, 64'(pos[0]), 64'(x));
      chk({tag, ".y"}, 64'(pos[1]), 64'(y));
      chk({tag, ".z"}, 64'(pos[2]), 64'(z));
   endtask

   // Drive one command for exactly one acceptance edge; returns in cycle T+1.
   task automatic send(input logic [1:0] op, input logic [3:0] spd, input logic [STEP_W-1:0] n,
                       input logic [3*K-1:0] tgt);
      bus.cmd_op     = op;
      bus.cmd_speed  = spd;
      bus.cmd_steps  = n;
      bus.cmd_target = tgt;
      bus.cmd_valid  = 1'b1;
      tick();
      bus.cmd_valid  = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 2'b00;
      bus.cmd_speed  = 4'b0001;
      bus.cmd_steps  = '0;
      bus.cmd_target = '0;
      bus.abort      = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst.mode", 64'(bus.mode), 64'h1);
      chk("rst.pos_mode", 64'(bus.pos_mode), 64'h1);
      chk("rst.jp", 64'(bus.jump_position), 64'h0);
      chk("rst.rdy_busy", 64'({bus.cmd_ready, bus.busy}), 64'b01);
      chk("rst.pulses", 64'({bus.done, bus.aborted, bus.err}), 64'h0);
      tick(); tick();
      rst_n = 1'b1;
      chk("init.pos_mode", 64'(bus.pos_mode), 64'h1);
      chk("init.rdy_busy", 64'({bus.cmd_ready, bus.busy}), 64'b01);
      tick();
      idle_chk("init_exit");
      pos_chk("init_pos", 0, 0, 0);

      // cruise attack, 5 steps
      send(2'b01, 4'b0010, 5, '0);
      for (int i = 1; i <= 5; i++) begin
         chk("cr5.mode", 64'(bus.mode), 64'h2);
         chk("cr5.pos_mode", 64'(bus.pos_mode), 64'h2);
         chk("cr5.rdy_done", 64'({bus.cmd_ready, bus.done}), 64'b00);
         tick();
      end
      chk("cr5.done", 64'(bus.done), 64'h1);
      idle_chk("cr5_end");
      pos_chk("cr5_pos", 5, 5, 5);
      tick();
      chk("cr5.done_1cyc", 64'(bus.done), 64'h0);

      // cruise with zero steps finishes immediately
      send(2'b01, 4'b0010, 0, '0);
      chk("cr0.done", 64'(bus.done), 64'h1);
      idle_chk("cr0");
      pos_chk("cr0_pos", 5, 5, 5);
      tick();
      chk("cr0.done_1cyc", 64'(bus.done), 64'h0);

      // jump with cmd_valid held high the whole time
      bus.cmd_op     = 2'b10;
      bus.cmd_target = {3{16'h0249}};
      bus.cmd_valid  = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         chk("jmp.rdy", 64'(bus.cmd_ready), 64'h0);
         chk("jmp.pos_mode", 64'(bus.pos_mode), (k == 5) ? 64'h4 : 64'h2);
         chk("jmp.mode", 64'(bus.mode), 64'h1);
         chk("jmp.done", 64'(bus.done), 64'h0);
         if (k == 5) chk("jmp.jp", 64'(bus.jump_position), 64'({3{16'h0249}}));
         tick();
      end
      bus.cmd_valid = 1'b0;
      chk("jmp.done_t9", 64'(bus.done), 64'h1);
      idle_chk("jmp_end");
      pos_chk("jmp_pos", 16'h0249, 16'h0249, 16'h0249);
      chk("jmp.jp_kept", 64'(bus.jump_position), 64'({3{16'h0249}}));

      // zero position
      send(2'b00, 4'b0000, 0, '0);
      chk("zero.pos_mode", 64'(bus.pos_mode), 64'h1);
      chk("zero.done_busy", 64'({bus.done, bus.busy}), 64'b01);
      tick();
      chk("zero.done", 64'(bus.done), 64'h1);
      idle_chk("zero_end");
      pos_chk("zero_pos", 0, 0, 0);

      // abort cruise in T+3
      send(2'b01, 4'b0100, 10, '0);
      chk("ab.mode", 64'(bus.mode), 64'h4);
      tick(); tick();
      bus.abort = 1'b1;
      chk("ab.mode_t3", 64'(bus.mode), 64'h4);
      tick();
      bus.abort = 1'b0;
      chk("ab.pulses", 64'({bus.done, bus.aborted, bus.err}), 64'b010);
      idle_chk("ab_end");
      pos_chk("ab_pos", 6, 6, 6);
      tick();
      chk("ab.pulse_1cyc", 64'({bus.done, bus.aborted}), 64'h0);

      // abort on the final cruise cycle beats done
      send(2'b01, 4'b1000, 2, '0);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abl.pulses", 64'({bus.done, bus.aborted}), 64'b01);
      pos_chk("abl_pos", 14, 14, 14);
      tick();
      chk("abl.no_done", 64'(bus.done), 64'h0);

      // abort during charge: no jump fires
      send(2'b10, 4'b0001, 0, {16'd3, 16'd2, 16'd1});
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abc.pulses", 64'({bus.done, bus.aborted}), 64'b01);
      idle_chk("abc_end");
      for (int k = 0; k < 6; k++) tick();
      chk("abc.jp_old", 64'(bus.jump_position), 64'({3{16'h0249}}));
      pos_chk("abc_pos", 14, 14, 14);

      // abort during jump and cooldown is ignored
      send(2'b10, 4'b0001, 0, {16'd3, 16'd2, 16'd1});
      for (int k = 0; k < 4; k++) tick();
      chk("abj.pos_mode", 64'(bus.pos_mode), 64'h4);
      bus.abort = 1'b1;
      for (int k = 6; k <= 8; k++) begin
         tick();
         chk("abj.cool", 64'({bus.aborted, bus.done, bus.busy}), 64'b001);
      end
      tick();
      bus.abort = 1'b0;
      chk("abj.pulses", 64'({bus.done, bus.aborted}), 64'b10);
      pos_chk("abj_pos", 1, 2, 3);

      // illegal op
      send(2'b11, 4'b0010, 3, '0);
      chk("ill.err", 64'({bus.err, bus.done, bus.aborted}), 64'b100);
      idle_chk("ill_op");
      tick();
      chk("ill.err_1cyc", 64'(bus.err), 64'h0);

      // cruise with a two-hot speed
      send(2'b01, 4'b0110, 3, '0);
      chk("ilsp.err", 64'({bus.err, bus.done}), 64'b10);
      idle_chk("ill_spd");
      tick(); tick(); tick();
      chk("ilsp.err_1cyc", 64'(bus.err), 64'h0);
      pos_chk("ill_pos", 1, 2, 3);

      // jump ignores speed; reset mid-charge drops it
      send(2'b10, 4'b0000, 0, {3{16'h1111}});
      chk("rsj.busy_err", 64'({bus.busy, bus.err}), 64'b10);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rsj.async", 64'({bus.mode, bus.pos_mode}), 64'h11);
      chk("rsj.rdy_busy", 64'({bus.cmd_ready, bus.busy}), 64'b01);
      tick(); tick();
      rst_n = 1'b1;
      chk("rsj.init", 64'(bus.pos_mode), 64'h1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rsj.no_pulse", 64'({bus.done, bus.aborted, bus.pos_mode}), 64'h2);
      end
      chk("rsj.jp", 64'(bus.jump_position), 64'h0);
      pos_chk("rsj_pos", 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
